// File: rtl/bcfg_register_bank.sv
// bcfg_register_bank: three host-writable 16-bit BCFG registers with decoded convolution-engine fields
module bcfg_register_bank #(
  parameter logic [15:0] Bcfg1ResetValue = 16'h0001,
  parameter logic [15:0] Bcfg2ResetValue = 16'h0000,
  parameter logic [15:0] Bcfg3ResetValue = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bcfg1_we_i,
  input  logic [15:0] bcfg1_data_i,
  input  logic        bcfg2_we_i,
  input  logic [15:0] bcfg2_data_i,
  input  logic        bcfg3_we_i,
  input  logic [15:0] bcfg3_data_i,
  output logic [15:0] bcfg1_o,
  output logic [15:0] bcfg2_o,
  output logic [15:0] bcfg3_o,
  output logic [11:0] engine_count_o,
  output logic [3:0]  shift_low_o,
  output logic [13:0] matrix_size_o,
  output logic [1:0]  shift_high_o,
  output logic [5:0]  shift_final_o,
  output logic [5:0]  shift_amount_o
);
  always_ff @(posedge clk_i) begin
    bcfg1_o <= !rst_i ? Bcfg1ResetValue : bcfg1_we_i ? bcfg1_data_i : bcfg1_o;
    bcfg2_o <= !rst_i ? Bcfg2ResetValue : bcfg2_we_i ? bcfg2_data_i : bcfg2_o;
    bcfg3_o <= !rst_i ? Bcfg3ResetValue : bcfg3_we_i ? bcfg3_data_i : bcfg3_o;
  end
  assign engine_count_o = bcfg1_o[11:0];
  assign shift_low_o    = bcfg1_o[15:12];
  assign matrix_size_o  = bcfg2_o[13:0];
  assign shift_high_o   = bcfg2_o[15:14];
  assign shift_final_o  = bcfg3_o[5:0];
  assign shift_amount_o = {shift_high_o, shift_low_o};
endmodule

// File: tb/tb_bcfg_register_bank.sv
// tb_bcfg_register_bank: table-driven and sequence checks of bcfg_register_bank
module tb_bcfg_register_bank;
  logic clk_i = 1'b0;
  logic rst_i;
  logic we1, we2, we3;
  logic [15:0] d1, d2, d3;
  logic [15:0] b1, b2, b3, p1, p2, p3;
  logic [11:0] ec, pec;
  logic [3:0] sl, psl;
  logic [13:0] ms, pms;
  logic [1:0] sh, psh;
  logic [5:0] sf, sa, psf, psa;
  int cmp = 0;
  int err = 0;
  typedef struct {
    logic we1; logic [15:0] d1;
    logic we2; logic [15:0] d2;
    logic we3; logic [15:0] d3;
    logic [15:0] e1, e2, e3;
  } vec_t;
  vec_t vt [8];
  always #5 clk_i = ~clk_i;
  bcfg_register_bank dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .bcfg1_we_i(we1), .bcfg1_data_i(d1),
    .bcfg2_we_i(we2), .bcfg2_data_i(d2),
    .bcfg3_we_i(we3), .bcfg3_data_i(d3),
    .bcfg1_o(b1), .bcfg2_o(b2), .bcfg3_o(b3),
    .engine_count_o(ec), .shift_low_o(sl), .matrix_size_o(ms),
    .shift_high_o(sh), .shift_final_o(sf), .shift_amount_o(sa)
  );
  bcfg_register_bank #(.Bcfg2ResetValue(16'h3FFF)) dut_p (
    .clk_i(clk_i), .rst_i(rst_i),
    .bcfg1_we_i(1'b0), .bcfg1_data_i(16'h0000),
    .bcfg2_we_i(1'b0), .bcfg2_data_i(16'h0000),
    .bcfg3_we_i(1'b0), .bcfg3_data_i(16'h0000),
    .bcfg1_o(p1), .bcfg2_o(p2), .bcfg3_o(p3),
    .engine_count_o(pec), .shift_low_o(psl), .matrix_size_o(pms),
    .shift_high_o(psh), .shift_final_o(psf), .shift_amount_o(psa)
  );
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    cmp++;
    if (a !== e) begin
      err++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic chk_all(input string tag, input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
    chk({tag, " bcfg1"}, b1, e1);
    chk({tag, " bcfg2"}, b2, e2);
    chk({tag, " bcfg3"}, b3, e3);
    chk({tag, " engine_count"}, {4'h0, ec}, {4'h0, e1[11:0]});
    chk({tag, " shift_low"}, {12'h0, sl}, {12'h0, e1[15:12]});
    chk({tag, " matrix_size"}, {2'h0, ms}, {2'h0, e2[13:0]});
    chk({tag, " shift_high"}, {14'h0, sh}, {14'h0, e2[15:14]});
    chk({tag, " shift_final"}, {10'h0, sf}, {10'h0, e3[5:0]});
    chk({tag, " shift_amount"}, {10'h0, sa}, {10'h0, e2[15:14], e1[15:12]});
  endtask
  task automatic step(input logic r, input logic w1, input logic [15:0] x1, input logic w2, input logic [15:0] x2, input logic w3, input logic [15:0] x3);
    rst_i = r; we1 = w1; d1 = x1; we2 = w2; d2 = x2; we3 = w3; d3 = x3;
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    vt[0] = '{1'b0, 16'hAAAA, 1'b0, 16'h5555, 1'b0, 16'h1234, 16'h0001, 16'h0000, 16'h0000};
    vt[1] = '{1'b1, 16'h0002, 1'b1, 16'h0005, 1'b0, 16'h9999, 16'h0002, 16'h0005, 16'h0000};
    vt[2] = '{1'b1, 16'hF00A, 1'b1, 16'hC000, 1'b0, 16'h0000, 16'hF00A, 16'hC000, 16'h0000};
    vt[3] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hFFC4, 16'hF00A, 16'hC000, 16'hFFC4};
    vt[4] = '{1'b0, 16'h1234, 1'b0, 16'h4321, 1'b0, 16'h0F0F, 16'hF00A, 16'hC000, 16'hFFC4};
    vt[5] = '{1'b1, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 16'hC000, 16'hFFC4};
    vt[6] = '{1'b0, 16'h7777, 1'b1, 16'h3FFF, 1'b1, 16'h0003, 16'h0000, 16'h3FFF, 16'h0003};
    vt[7] = '{1'b1, 16'h8001, 1'b1, 16'h4001, 1'b1, 16'h0040, 16'h8001, 16'h4001, 16'h0040};
    step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk_all("reset", 16'h0001, 16'h0000, 16'h0000);
    chk("reset engine_count=1", {4'h0, ec}, 16'd1);
    chk("reset shift_amount=0", {10'h0, sa}, 16'd0);
    chk("param reset matrix_size", {2'h0, pms}, 16'd16383);
    chk("param reset shift_high", {14'h0, psh}, 16'd0);
    chk("param reset bcfg1", p1, 16'h0001);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vt[i].we1, vt[i].d1, vt[i].we2, vt[i].d2, vt[i].we3, vt[i].d3);
      chk_all($sformatf("vec%0d", i), vt[i].e1, vt[i].e2, vt[i].e3);
      if (i == 2) begin
        chk("vec2 shift_amount=63", {10'h0, sa}, 16'd63);
        chk("vec2 engine_count=10", {4'h0, ec}, 16'd10);
        chk("vec2 matrix_size=0", {2'h0, ms}, 16'd0);
      end
    end
    step(1'b1, 1'b1, 16'h000C, 1'b1, 16'h0011, 1'b1, 16'hFFC4);
    chk_all("preload", 16'h000C, 16'h0011, 16'hFFC4);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 16'($urandom), 1'b0, 16'($urandom), 1'b0, 16'($urandom));
      chk_all($sformatf("hold%0d", i), 16'h000C, 16'h0011, 16'hFFC4);
    end
    step(1'b0, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF);
    chk_all("reset beats write", 16'h0001, 16'h0000, 16'h0000);
    step(1'b1, 1'b0, 16'h0, 1'b1, 16'h2222, 1'b0, 16'h0);
    chk_all("post-reset single write", 16'h0001, 16'h2222, 16'h0000);
    step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk_all("mid reset", 16'h0001, 16'h0000, 16'h0000);
    chk("param mid reset bcfg2", p2, 16'h3FFF);
    step(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk_all("idle after reset", 16'h0001, 16'h0000, 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
